// File: rtl/excp_redirect_ctrl_pkg.sv
// Shared types and constants for the exception/redirect sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package excp_redirect_ctrl_pkg;

   // Default exception code width (estat.ecode)
   localparam int ECODE_W = 6;

   // Stage bit positions inside the stall vector
   localparam int STG_PC_REG  = 0;
   localparam int STG_IF_BUF1 = 1;
   localparam int STG_IF_ID   = 2;
   localparam int STG_ID_EX   = 3;
   localparam int STG_EX_MEM  = 4;
   localparam int STG_MEM_WB  = 5;
   localparam int STG_CTRL    = 6;
   localparam int NUM_STG     = 7;

   // Stall vectors: a requesting stage freezes itself and everything upstream
   localparam logic [NUM_STG-1:0] STALL_NONE = 7'b0000000;
   localparam logic [NUM_STG-1:0] STALL_ID   = 7'b0001111;
   localparam logic [NUM_STG-1:0] STALL_EX   = 7'b0011111;
   localparam logic [NUM_STG-1:0] STALL_MEM  = 7'b0111111;
   localparam logic [NUM_STG-1:0] STALL_ALL  = 7'b1111111;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_RECOVER  = 2'd3
   } state_e;

endpackage

// File: rtl/excp_redirect_ctrl_stall_prio_enc.sv
// Normal-operation stall priority encoder: the deepest requesting stage wins.
// Latency: combinational.
// Backpressure: none; pure decode of the three stall requests.
module excp_redirect_ctrl_stall_prio_enc
   import excp_redirect_ctrl_pkg::*;
(
   input  logic               stallreq_id_i,
   input  logic               stallreq_ex_i,
   input  logic               stallreq_mem_i,
   output logic [NUM_STG-1:0] stall_o
);

   // MEM outranks EX outranks ID, since a deeper stall covers the shallower ones
   always_comb begin
      stall_o = STALL_NONE;
      if (stallreq_mem_i) begin
         stall_o = STALL_MEM;
      end else if (stallreq_ex_i) begin
         stall_o = STALL_EX;
      end else if (stallreq_id_i) begin
         stall_o = STALL_ID;
      end
   end

endmodule

// File: rtl/excp_redirect_ctrl.sv
// Pipeline stall/flush/redirect sequencer: freezes on exception/ERTN, drains stores, redirects.
// Latency: redirect strobe 1 cycle after the event, plus one cycle per DRAIN cycle.
// Backpressure: mem_busy_i holds the sequence in DRAIN up to DRAIN_MAX cycles.
module excp_redirect_ctrl #(
   parameter int RECOVER_CYCLES = 2,
   parameter int DRAIN_MAX      = 64,
   parameter int ECODE_W        = excp_redirect_ctrl_pkg::ECODE_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stallreq_id_i,
   input  logic               stallreq_ex_i,
   input  logic               stallreq_mem_i,
   input  logic               excp_valid_i,
   input  logic [ECODE_W-1:0] excp_code_i,
   input  logic [31:0]        excp_pc_i,
   input  logic               ertn_valid_i,
   input  logic [31:0]        eentry_i,
   input  logic [31:0]        era_i,
   input  logic               mem_busy_i,
   output logic [6:0]         stall_o,
   output logic               flush_o,
   output logic               redirect_valid_o,
   output logic [31:0]        redirect_pc_o,
   output logic               csr_excp_we_o,
   output logic [31:0]        csr_era_o,
   output logic [ECODE_W-1:0] csr_ecode_o,
   output logic               drain_timeout_o
);

   import excp_redirect_ctrl_pkg::*;

   // One counter serves both DRAIN and RECOVER; it is cleared on entry to either
   localparam int CNT_MAX = (DRAIN_MAX > RECOVER_CYCLES) ? DRAIN_MAX : RECOVER_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'((DRAIN_MAX > 0) ? DRAIN_MAX - 1 : 0);
   localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [31:0]          target_q, target_d;
   logic                 is_excp_q, is_excp_d;
   logic [31:0]          pc_q, pc_d;
   logic [ECODE_W-1:0]   code_q, code_d;
   logic [31:0]          redirect_pc_q;
   logic                 timeout_q, timeout_d;
   logic [NUM_STG-1:0]   stall_run;
   logic                 event_vld;

   excp_redirect_ctrl_stall_prio_enc u_stall_prio_enc (
      .stallreq_id_i  (stallreq_id_i),
      .stallreq_ex_i  (stallreq_ex_i),
      .stallreq_mem_i (stallreq_mem_i),
      .stall_o        (stall_run)
   );

   assign event_vld = excp_valid_i | ertn_valid_i;

   // Next-state and output decode; stall/event inputs only matter in RUN
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      target_d         = target_q;
      is_excp_d        = is_excp_q;
      pc_d             = pc_q;
      code_d           = code_q;
      timeout_d        = timeout_q;
      stall_o          = STALL_NONE;
      flush_o          = 1'b0;
      redirect_valid_o = 1'b0;
      csr_excp_we_o    = 1'b0;
      case (state_q)
         ST_RUN: begin
            stall_o = stall_run;
            if (event_vld) begin
               stall_o   = STALL_ALL;
               // Exception beats a simultaneous ERTN; the ERTN is simply dropped
               is_excp_d = excp_valid_i;
               target_d  = excp_valid_i ? eentry_i : era_i;
               pc_d      = excp_pc_i;
               code_d    = excp_code_i;
               cnt_d     = '0;
               state_d   = mem_busy_i ? ST_DRAIN : ST_REDIRECT;
            end
         end
         ST_DRAIN: begin
            stall_o = STALL_ALL;
            cnt_d   = cnt_q + 1'b1;
            if (!mem_busy_i) begin
               state_d = ST_REDIRECT;
            end else if (cnt_q == DRAIN_LAST) begin
               // Bus never went idle: give up waiting and flag it
               timeout_d = 1'b1;
               state_d   = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            flush_o          = 1'b1;
            redirect_valid_o = 1'b1;
            csr_excp_we_o    = is_excp_q;
            cnt_d            = '0;
            state_d          = (RECOVER_CYCLES > 0) ? ST_RECOVER : ST_RUN;
         end
         ST_RECOVER: begin
            flush_o = 1'b1;
            if (cnt_q == RECOVER_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and latched-event registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         target_q      <= '0;
         is_excp_q     <= 1'b0;
         pc_q          <= '0;
         code_q        <= '0;
         redirect_pc_q <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         target_q  <= target_d;
         is_excp_q <= is_excp_d;
         pc_q      <= pc_d;
         code_q    <= code_d;
         timeout_q <= timeout_d;
         // Load only when entering REDIRECT so the target holds at all other times
         if (state_d == ST_REDIRECT) begin
            redirect_pc_q <= target_d;
         end
      end
   end

   assign redirect_pc_o   = redirect_pc_q;
   assign drain_timeout_o = timeout_q;
   assign csr_era_o       = csr_excp_we_o ? pc_q : 32'h0;
   assign csr_ecode_o     = csr_excp_we_o ? code_q : '0;

endmodule

// File: doc/excp_redirect_ctrl.md
Name: excp_redirect_ctrl

Overview:
- Sequencing controller for the pipeline stall/flush/redirect network.
- Aggregates stall requests from ID, EX and MEM.
- On an exception or ERTN it freezes the pipe, drains outstanding memory stores, then issues a one-cycle redirect with a multi-cycle flush window.
- Sits beside the pipeline registers; its stall vector and flush drive pc_reg, if_buffer_1, if_id, id_ex, ex_mem and mem_wb.

Parameters:
RECOVER_CYCLES, 2, extra cycles flush stays high after the redirect cycle (0 allowed)
DRAIN_MAX, 64, maximum DRAIN cycles before forced redirect
ECODE_W, 6, exception code width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
stallreq_id_i  in  1  ID hazard stall request
stallreq_ex_i  in  1  EX multi-cycle stall request
stallreq_mem_i  in  1  MEM cache-miss stall request
excp_valid_i  in  1  exception detected at MEM commit point
excp_code_i  in  ECODE_W  exception code
excp_pc_i  in  32  PC of excepting instruction
ertn_valid_i  in  1  ERTN reached commit point
eentry_i  in  32  exception entry address (CSR)
era_i  in  32  return address (CSR)
mem_busy_i  in  1  store buffer / bus transaction outstanding
stall_o  out  7  [0]pc_reg [1]if_buffer_1 [2]if_id [3]id_ex [4]ex_mem [5]mem_wb [6]ctrl
flush_o  out  1  pipeline flush
redirect_valid_o  out  1  one-cycle PC redirect strobe
redirect_pc_o  out  32  redirect target
csr_excp_we_o  out  1  one-cycle strobe: write era and estat.ecode
csr_era_o  out  32  value for era
csr_ecode_o  out  ECODE_W  value for estat.ecode
drain_timeout_o  out  1  sticky: DRAIN hit DRAIN_MAX

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=RUN; all registered outputs 0; redirect_pc_o=0; drain_timeout_o cleared.
  - Reset mid-sequence aborts the sequence with no redirect.
- States: RUN, DRAIN, REDIRECT, RECOVER.
- RUN, no event, stall_o combinational with priority mem > ex > id:
  - mem -> 7'b0111111
  - ex -> 7'b0011111
  - id -> 7'b0001111
  - otherwise 0
  - flush_o=0.
- RUN, event cycle (excp_valid_i or ertn_valid_i):
  - stall_o=7'b1111111 combinationally.
  - Latch target = eentry_i (exception) or era_i (ERTN).
  - Latch is_excp, excp_pc_i and excp_code_i.
  - If both events arrive together, the exception wins and the ERTN is dropped.
  - Next state is DRAIN if mem_busy_i=1, else REDIRECT.
- DRAIN:
  - stall_o=7'b1111111; a counter increments each cycle.
  - Leave to REDIRECT on the first cycle mem_busy_i=0.
  - If the counter reaches DRAIN_MAX, set drain_timeout_o (sticky until reset) and go to REDIRECT anyway.
- REDIRECT (exactly 1 cycle):
  - stall_o=0, flush_o=1, redirect_valid_o=1, redirect_pc_o=latched target.
  - If is_excp: csr_excp_we_o=1, csr_era_o=latched pc, csr_ecode_o=latched code. ERTN does not write the CSRs.
  - Next: RECOVER if RECOVER_CYCLES>0, else RUN.
- RECOVER:
  - flush_o=1, stall_o=0 for RECOVER_CYCLES cycles (counter), then RUN.
- Event and stall inputs are ignored in DRAIN, REDIRECT and RECOVER; events are not queued.
- Outputs:
  - redirect_valid_o and csr_excp_we_o are high only in REDIRECT.
  - redirect_pc_o holds its last value outside REDIRECT.
- Latency, event cycle to redirect strobe:
  - 1 cycle if not busy.
  - 1 + N if mem_busy_i is high for N DRAIN cycles.
- Counters are sized clog2(max(DRAIN_MAX, RECOVER_CYCLES)+1) and are cleared on entry to their state.

Decomposition:
- Shared package:
  - stall vector constants STALL_NONE / STALL_ID / STALL_EX / STALL_MEM / STALL_ALL.
  - State encoding.
  - Stage bit index constants.
  - ECODE_W.
- Natural sub-module: stall_prio_enc (combinational RUN-state stall priority encoder); all else inline.

Test Plan:
- Stall priority in RUN:
  - stallreq_id=1 -> stall_o=0x0F; add ex -> 0x1F; add mem -> 0x3F.
  - Deassert all -> 0x00, flush_o=0 throughout.
- Exception, not busy:
  - excp_valid=1, code=0x0B, pc=0x1C00_0040, eentry=0x1C00_8000.
  - Event cycle stall=0x7F.
  - Next cycle redirect_valid=1, redirect_pc=0x1C00_8000, csr_excp_we=1, era=0x1C00_0040, ecode=0x0B, flush=1.
  - flush stays 1 for 2 more cycles, then stall/flush=0.
- ERTN with drain:
  - ertn_valid=1, era_i=0x1C00_0044, mem_busy=1 for 3 cycles.
  - stall=0x7F for 4 cycles, redirect_pc=0x1C00_0044 on the 5th, csr_excp_we=0.
- Simultaneous exception + ERTN -> exception target eentry used, csr_excp_we=1; a new excp_valid pulse during RECOVER is ignored (single redirect).
- Drain timeout:
  - mem_busy held 1 with DRAIN_MAX=64.
  - Redirect fires 65 cycles after the event cycle; drain_timeout_o=1 and stays 1 until rst_n=0.
- Reset mid-DRAIN: rst_n=0 for one cycle -> no redirect, all outputs 0, state RUN, stall follows requests next cycle.
